spi_target_shifter: RTL and testbench

SPI target (slave-side) serial engine. It receives SCK, SS_n and MOSI from an external SPI controller and drives MISO. It is the counterpart to the controller-side SCK generator: it oversamples the incoming SCK on the system clock, detects edges per CPOL/CPHA, and shifts fixed-width words. It presents received words and accepts transmit words over a simple valid/ready interface to the bus-side register block.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_target_shifter.sv | 151 +++++++++++++++
 tb/tb_spi_target_shifter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target serial engine.
`timescale 1ns/1ps
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    // SCK must be sampled at least this many CLK cycles per SCK period.
    localparam int MIN_OVERSAMPLE = 4;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with an extra history flop for rise/fall pulse detection.
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int              WIDTH       = 1,
    parameter int              SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
            prev_q <= RST_VAL;
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign level_o = stage_q[SYNC_STAGES-1];
    assign rise_o  = stage_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~stage_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_target_shifter.sv
// SPI target serial engine: oversampled SCK edge detection, word shifting in both
// directions, and a valid/ready holding register toward the bus side.
`timescale 1ns/1ps
module spi_target_shifter
    import spi_pkg::*;
#(
    parameter int NUMBITS     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               polarity,
    input  logic               phase,
    input  logic               msb_first,
    input  logic               SCK_in,
    input  logic               SS_n,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISO_oe,
    input  logic [NUMBITS-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [NUMBITS-1:0] rx_data,
    output logic               rx_valid,
    output logic               tx_underrun,
    output logic               busy
);

    localparam int               CNT_W    = $clog2(NUMBITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBITS - 1);

    logic sck_sync, sck_rise, sck_fall;
    logic ss_sync, mosi_sync;
    logic [1:0] lvl_rise_unused, lvl_fall_unused;

    spi_sync_edge #(
        .WIDTH       (1),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (1'b0)
    ) u_sync_sck (
        .clk_i   (CLK),
        .rst_i   (RST),
        .async_i (SCK_in),
        .level_o (sck_sync),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_sync_edge #(
        .WIDTH       (2),
        .SYNC_STAGES (SYNC_STAGES),
        .RST_VAL     (2'b10)
    ) u_sync_lvl (
        .clk_i   (CLK),
        .rst_i   (RST),
        .async_i ({SS_n, MOSI}),
        .level_o ({ss_sync, mosi_sync}),
        .rise_o  (lvl_rise_unused),
        .fall_o  (lvl_fall_unused)
    );

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUMBITS-1:0] tx_shift_q, rx_shift_q, hold_q, rx_data_q;
    logic               hold_full_q, rx_valid_q, underrun_q;

    logic               lead_edge, trail_edge, sample_evt, shift_evt;
    logic               abort, word_done, word_start, take, load;
    logic               hold_full_d;
    logic [NUMBITS-1:0] hold_d, start_word, rx_next, tx_next;

    always_comb begin
        lead_edge  = polarity ? sck_fall : sck_rise;
        trail_edge = polarity ? sck_rise : sck_fall;
        sample_evt = (state_q == ACTIVE) && (phase ? trail_edge : lead_edge);
        // A shift edge with count 0 is either the reload gap or the first leading edge of a phase-1 word.
        shift_evt  = (state_q == ACTIVE) && (phase ? lead_edge : trail_edge) && (cnt_q != '0);
        abort      = !enable || ss_sync;
        word_done  = sample_evt && (cnt_q == LAST_IDX);
        word_start = !abort && ((state_q == LOAD) || word_done);
        take       = word_start && hold_full_q;
        load       = tx_valid && !hold_full_q;
        hold_full_d = (hold_full_q && !take) || load;
        hold_d      = load ? tx_data : hold_q;
        start_word  = hold_full_q ? hold_q : '0;
        rx_next = msb_first ? {rx_shift_q[NUMBITS-2:0], mosi_sync}
                            : {mosi_sync, rx_shift_q[NUMBITS-1:1]};
        tx_next = msb_first ? {tx_shift_q[NUMBITS-2:0], 1'b0}
                            : {1'b0, tx_shift_q[NUMBITS-1:1]};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            if (abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= LOAD;
                    LOAD: begin
                        tx_shift_q <= start_word;
                        underrun_q <= ~hold_full_q;
                        cnt_q      <= '0;
                        state_q    <= ACTIVE;
                    end
                    ACTIVE: begin
                        if (sample_evt) begin
                            rx_shift_q <= rx_next;
                            if (word_done) begin
                                rx_data_q  <= rx_next;
                                rx_valid_q <= 1'b1;
                                cnt_q      <= '0;
                                tx_shift_q <= start_word;
                                underrun_q <= ~hold_full_q;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else if (shift_evt) begin
                            tx_shift_q <= tx_next;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign MISO_oe     = busy;
    assign MISO        = busy && (msb_first ? tx_shift_q[NUMBITS-1] : tx_shift_q[0]);
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_target_shifter.sv
// Directed bench for spi_target_shifter: SPI controller model plus rx scoreboard.
`timescale 1ns/1ps
module tb_spi_target_shifter;

    localparam int NB   = 8;
    localparam int HALF = 4;

    logic          CLK, RST, enable, polarity, phase, msb_first;
    logic          SCK_in, SS_n, MOSI, MISO, MISO_oe;
    logic [NB-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, tx_underrun, busy;

    int vectors = 0;
    int fails   = 0;
    int rx_cnt  = 0;
    int und_cnt = 0;
    logic [NB-1:0] exp_q [$];

    spi_target_shifter #(.NUMBITS(NB), .SYNC_STAGES(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .polarity    (polarity),
        .phase       (phase),
        .msb_first   (msb_first),
        .SCK_in      (SCK_in),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .MISO_oe     (MISO_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rx_valid pulse consumes one expected word.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            if (tx_underrun === 1'b1) und_cnt++;
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                check("rx_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_tx(input logic [NB-1:0] d);
        @(negedge CLK);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
    endtask

    // Controller model: drives SCK/MOSI per current mode, samples MISO on the sample edge.
    task automatic xfer(input logic [NB-1:0] mo, input int nbits, input bit start,
                        input bit stop, input bit chk_ready,
                        output logic [NB-1:0] mi, output int und_delta);
        int und0;
        int idx;
        int guard;
        mi = '0;
        und0 = und_cnt;
        und_delta = 0;
        if (start) begin
            @(negedge CLK);
            SS_n = 1'b0;
            guard = 0;
            while (busy !== 1'b1 && guard < 12) begin
                @(negedge CLK);
                guard++;
            end
            check("busy_rise", 32'(busy), 32'd1);
            if (chk_ready) begin
                check("tx_ready_in_load", 32'(tx_ready), 32'd0);
                @(negedge CLK);
                check("tx_ready_after_load", 32'(tx_ready), 32'd1);
            end
            repeat (4) @(negedge CLK);
        end
        for (int i = 0; i < nbits; i++) begin
            idx = msb_first ? (NB - 1 - i) : i;
            if (!phase) begin
                MOSI = mo[idx];
                repeat (HALF) @(negedge CLK);
                SCK_in = ~polarity;
                mi[idx] = MISO;
                if (i == nbits - 1) und_delta = und_cnt - und0;
                repeat (HALF) @(negedge CLK);
                SCK_in = polarity;
            end else begin
                SCK_in = ~polarity;
                MOSI = mo[idx];
                repeat (HALF) @(negedge CLK);
                SCK_in = polarity;
                mi[idx] = MISO;
                if (i == nbits - 1) und_delta = und_cnt - und0;
                repeat (HALF) @(negedge CLK);
            end
        end
        if (stop) begin
            repeat (HALF) @(negedge CLK);
            SS_n = 1'b1;
            repeat (6) @(negedge CLK);
        end
    endtask

    initial begin
        logic [NB-1:0] mi, mi2;
        int ud, ud2, rx0;

        RST = 1'b1; SS_n = 1'b0; enable = 1'b1;
        polarity = 1'b0; phase = 1'b0; msb_first = 1'b1;
        SCK_in = 1'b0; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;

        // Reset with target selected
        repeat (2) @(negedge CLK);
        check("rst_miso_oe", 32'(MISO_oe), 32'd0);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        SS_n = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (4) @(negedge CLK);
        check("idle_busy", 32'(busy), 32'd0);

        // Mode 0, MSB first
        push_tx(8'hA5);
        check("tx_ready_full", 32'(tx_ready), 32'd0);
        exp_q.push_back(8'h3C);
        rx0 = rx_cnt;
        xfer(8'h3C, NB, 1, 1, 1, mi, ud);
        check("m0_miso_word", 32'(mi), 32'hA5);
        check("m0_no_underrun", 32'(ud), 32'd0);
        check("m0_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
        check("m0_idle_oe", 32'(MISO_oe), 32'd0);

        // Mode 3, LSB first, back-to-back words with mid-word refill
        @(negedge CLK);
        polarity = 1'b1; phase = 1'b1; msb_first = 1'b0; SCK_in = 1'b1;
        repeat (4) @(negedge CLK);
        push_tx(8'hC3);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h7E);
        rx0 = rx_cnt;
        fork
            xfer(8'h81, NB, 1, 0, 0, mi, ud);
            begin
                repeat (20) @(negedge CLK);
                push_tx(8'h55);
            end
        join
        xfer(8'h7E, NB, 0, 1, 0, mi2, ud2);
        check("m3_miso_word1", 32'(mi), 32'hC3);
        check("m3_miso_word2", 32'(mi2), 32'h55);
        check("m3_no_underrun", 32'(ud + ud2), 32'd0);
        check("m3_rx_pulses", 32'(rx_cnt - rx0), 32'd2);

        // Underrun: nothing loaded before select
        @(negedge CLK);
        polarity = 1'b0; phase = 1'b0; msb_first = 1'b1; SCK_in = 1'b0;
        repeat (4) @(negedge CLK);
        check("ur_tx_ready", 32'(tx_ready), 32'd1);
        exp_q.push_back(8'h96);
        rx0 = rx_cnt;
        xfer(8'h96, NB, 1, 1, 0, mi, ud);
        check("ur_miso_zero", 32'(mi), 32'h00);
        check("ur_one_pulse", 32'(ud), 32'd1);
        check("ur_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

        // Abort after 5 of 8 bits, then a clean word
        rx0 = rx_cnt;
        xfer(8'hAA, 5, 1, 1, 0, mi, ud);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_miso_oe", 32'(MISO_oe), 32'd0);
        check("ab_no_rx", 32'(rx_cnt - rx0), 32'd0);
        push_tx(8'h3A);
        exp_q.push_back(8'hF0);
        rx0 = rx_cnt;
        xfer(8'hF0, NB, 1, 1, 0, mi, ud);
        check("ab_next_miso", 32'(mi), 32'h3A);
        check("ab_next_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

        // Enable drop mid-word with SS_n held low, then re-enable
        rx0 = rx_cnt;
        xfer(8'h5A, 3, 1, 0, 0, mi, ud);
        @(negedge CLK);
        enable = 1'b0;
        repeat (4) @(negedge CLK);
        check("en_busy", 32'(busy), 32'd0);
        check("en_miso_oe", 32'(MISO_oe), 32'd0);
        check("en_miso", 32'(MISO), 32'd0);
        check("en_no_rx", 32'(rx_cnt - rx0), 32'd0);
        push_tx(8'hC6);
        exp_q.push_back(8'h69);
        enable = 1'b1;
        xfer(8'h69, NB, 1, 1, 0, mi, ud);
        check("en_next_miso", 32'(mi), 32'hC6);
        check("en_next_rx_pulses", 32'(rx_cnt - rx0), 32'd1);

        repeat (10) @(negedge CLK);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("rx_total", 32'(rx_cnt), 32'd6);
        check("rx_data_held", 32'(rx_data), 32'h69);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
